// File: rtl/instr_mem_responder.sv
// Instruction memory on the core's fetch port with programmable grant and
// response wait-states; a side load port fills the word array at any time.
module instr_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int IW         = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_gnt,
  output logic                  instr_rvalid,
  output logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic [3:0]            gnt_wait,
  input  logic [3:0]            rvalid_wait,
  input  logic                  load_we,
  input  logic [IW-1:0]         load_idx,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {IDLE, GNT_WAIT, RESP_WAIT} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state;
  logic [3:0]            gcnt;
  logic [3:0]            rcnt;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [31:0]           count_q;

  logic                  ready;
  logic                  grant;
  logic [IW-1:0]         idx;
  logic                  unused_addr_bits;

  // Word index; upper address bits alias so the array wraps.
  assign idx              = instr_addr[IW+1:2];
  assign unused_addr_bits = ^{instr_addr[ADDR_WIDTH-1:IW+2], instr_addr[1:0]};

  // The rvalid cycle is as free as IDLE, which gives one word per cycle.
  assign ready = (state == IDLE) || (state == RESP_WAIT && rvalid_q);
  assign grant = !rst && instr_req &&
                 ((ready && gnt_wait == 4'd0) || (state == GNT_WAIT && gcnt == 4'd1));

  assign instr_gnt    = grant;
  assign instr_rvalid = rvalid_q;
  assign instr_rdata  = rvalid_q ? data_q : '0;
  assign fetch_count  = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gcnt     <= 4'd0;
      rcnt     <= 4'd0;
      rvalid_q <= 1'b0;
      data_q   <= '0;
      count_q  <= 32'd0;
    end else begin
      rvalid_q <= 1'b0;
      if (rvalid_q) count_q <= count_q + 32'd1;

      if (grant) begin
        // Non-blocking read sees the pre-load word on a same-cycle load.
        state    <= RESP_WAIT;
        gcnt     <= 4'd0;
        data_q   <= mem[idx];
        rcnt     <= rvalid_wait;
        rvalid_q <= (rvalid_wait == 4'd0);
      end else if (ready) begin
        if (instr_req) begin
          state <= GNT_WAIT;
          gcnt  <= gnt_wait;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          GNT_WAIT: begin
            if (!instr_req) begin
              state <= IDLE;
              gcnt  <= 4'd0;
            end else begin
              gcnt <= gcnt - 4'd1;
            end
          end
          RESP_WAIT: begin
            rcnt     <= rcnt - 4'd1;
            rvalid_q <= (rcnt == 4'd1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Loads ignore rst: the array contents survive reset.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_idx] <= load_data;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a cycle-timestamp model checks every
// cycle, and per-test literal expectations pin that model.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic [3:0]  gnt_wait;
  logic [3:0]  rvalid_wait;
  logic        load_we;
  logic [9:0]  load_idx;
  logic [31:0] load_data;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  instr_mem_responder dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .gnt_wait(gnt_wait), .rvalid_wait(rvalid_wait),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: grant and rvalid are due at absolute cycle numbers derived from
  // the latency rules; -1 means nothing scheduled.
  logic [31:0] mmem [0:1023];
  int          c       = 0;
  int          pend_at = -1;
  int          rv_at   = -1;
  logic [31:0] rv_data = '0;
  logic [31:0] m_cnt   = '0;

  always @(negedge clk) begin
    logic        e_gnt, e_rv;
    logic [31:0] e_data, e_cnt;
    c++;
    if (rst) begin
      pend_at = -1;
      rv_at   = -1;
      m_cnt   = '0;
    end else begin
      e_rv   = (rv_at == c);
      e_data = e_rv ? rv_data : 32'd0;
      e_cnt  = m_cnt;
      e_gnt  = 1'b0;
      if (pend_at >= 0) begin
        if (!instr_req) pend_at = -1;
        else if (c == pend_at) e_gnt = 1'b1;
      end else if (instr_req && (rv_at < 0 || rv_at == c)) begin
        if (gnt_wait == 4'd0) e_gnt = 1'b1;
        else pend_at = c + int'(gnt_wait);
      end
      if (e_rv) begin
        m_cnt = m_cnt + 32'd1;
        rv_at = -1;
      end
      if (e_gnt) begin
        rv_data = mmem[(instr_addr >> 2) % 1024];
        rv_at   = c + int'(rvalid_wait) + 1;
        pend_at = -1;
      end
      chk("model gnt", {31'd0, instr_gnt}, {31'd0, e_gnt});
      chk("model rvalid", {31'd0, instr_rvalid}, {31'd0, e_rv});
      chk("model rdata", instr_rdata, e_data);
      chk("model fetch_count", fetch_count, e_cnt);
    end
    if (load_we) mmem[load_idx] = load_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] w [0:3];

  initial begin
    w[0] = 32'h00000013; w[1] = 32'h00100093;
    w[2] = 32'h00200113; w[3] = 32'h00300193;
    rst = 1'b1; instr_req = 1'b0; instr_addr = '0;
    gnt_wait = '0; rvalid_wait = '0;
    load_we = 1'b0; load_idx = '0; load_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    look();
    chk("reset gnt", {31'd0, instr_gnt}, 32'd0);
    chk("reset rvalid", {31'd0, instr_rvalid}, 32'd0);
    chk("reset rdata", instr_rdata, 32'd0);
    chk("reset count", fetch_count, 32'd0);
    tick();

    // Fill the array
    for (int i = 0; i < 4; i++) begin
      load_we = 1'b1; load_idx = 10'(i); load_data = w[i];
      tick();
    end
    load_idx = 10'd5; load_data = 32'hAAAAAAAA;
    tick();
    load_we = 1'b0;
    tick();

    // Zero-wait streaming, address advanced on each grant
    for (int i = 0; i < 4; i++) begin
      instr_req = 1'b1; instr_addr = 32'(4 * i);
      look();
      chk("stream gnt", {31'd0, instr_gnt}, 32'd1);
      chk("stream rvalid", {31'd0, instr_rvalid}, (i > 0) ? 32'd1 : 32'd0);
      chk("stream rdata", instr_rdata, (i > 0) ? w[i-1] : 32'd0);
      tick();
    end
    instr_req = 1'b0;
    look();
    chk("stream last rdata", instr_rdata, 32'h00300193);
    tick();
    look();
    chk("stream count", fetch_count, 32'd4);
    chk("stream idle rvalid", {31'd0, instr_rvalid}, 32'd0);
    tick();

    // gnt_wait=3, rvalid_wait=2: grant 3 cycles after req, rvalid 3 after grant
    gnt_wait = 4'd3; rvalid_wait = 4'd2;
    instr_req = 1'b1; instr_addr = 32'h8;
    for (int k = 0; k < 9; k++) begin
      look();
      chk("wait gnt", {31'd0, instr_gnt}, (k == 3) ? 32'd1 : 32'd0);
      chk("wait rvalid", {31'd0, instr_rvalid}, (k == 6) ? 32'd1 : 32'd0);
      if (k == 6) chk("wait rdata", instr_rdata, 32'h00200113);
      tick();
      if (k == 3) instr_req = 1'b0;
    end

    // Wrapped, misaligned address selects word 1
    gnt_wait = 4'd0; rvalid_wait = 4'd0;
    instr_req = 1'b1; instr_addr = 32'h1006;
    look();
    chk("wrap gnt", {31'd0, instr_gnt}, 32'd1);
    tick();
    instr_req = 1'b0;
    look();
    chk("wrap rdata", instr_rdata, 32'h00100093);
    tick();

    // Same-cycle load to the granted word returns the old contents
    rvalid_wait = 4'd1;
    instr_req = 1'b1; instr_addr = 32'h14;
    load_we = 1'b1; load_idx = 10'd5; load_data = 32'h55555555;
    look();
    chk("rbw gnt", {31'd0, instr_gnt}, 32'd1);
    tick();
    instr_req = 1'b0; load_we = 1'b0;
    look();
    chk("rbw early rvalid", {31'd0, instr_rvalid}, 32'd0);
    tick();
    look();
    chk("rbw old rdata", instr_rdata, 32'hAAAAAAAA);
    tick();
    rvalid_wait = 4'd0;
    instr_req = 1'b1;
    look();
    tick();
    instr_req = 1'b0;
    look();
    chk("rbw new rdata", instr_rdata, 32'h55555555);
    tick();

    // Reset between grant and rvalid drops the fetch
    rvalid_wait = 4'd3;
    instr_req = 1'b1; instr_addr = 32'h0;
    look();
    chk("abort gnt", {31'd0, instr_gnt}, 32'd1);
    tick();
    instr_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      look();
      chk("abort rvalid", {31'd0, instr_rvalid}, 32'd0);
      if (k == 0) chk("abort count", fetch_count, 32'd0);
      tick();
    end
    rvalid_wait = 4'd0;
    instr_req = 1'b1; instr_addr = 32'h0;
    look();
    tick();
    instr_req = 1'b0;
    look();
    chk("abort array kept", instr_rdata, 32'h00000013);
    tick();

    // Request withdrawn before grant: nothing issued
    gnt_wait = 4'd2;
    instr_req = 1'b1; instr_addr = 32'hC;
    look();
    chk("drop gnt", {31'd0, instr_gnt}, 32'd0);
    tick();
    instr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("drop gnt", {31'd0, instr_gnt}, 32'd0);
      chk("drop rvalid", {31'd0, instr_rvalid}, 32'd0);
      tick();
    end
    look();
    chk("drop count", fetch_count, 32'd1);
    tick();
    gnt_wait = 4'd0;
    instr_req = 1'b1;
    look();
    chk("drop idle gnt", {31'd0, instr_gnt}, 32'd1);
    tick();
    instr_req = 1'b0;
    look();
    chk("drop idle rdata", instr_rdata, 32'h00300193);
    tick();

    // Held request with mixed waits, checked by the model only
    gnt_wait = 4'd1; rvalid_wait = 4'd1;
    instr_req = 1'b1; instr_addr = 32'h4;
    repeat (10) tick();
    gnt_wait = 4'd0; rvalid_wait = 4'd2; instr_addr = 32'h8;
    repeat (10) tick();
    instr_req = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Behavioural-synthesisable instruction memory that answers the core's fetch port (instr_req / instr_gnt / instr_rvalid / instr_rdata) with programmable grant and response wait-states. It sits between the core's IF stage and the bus that the IF tracker snoops. It provides the responder side of the fetch handshake, so tracker timing can be exercised against controlled memory latencies. A side load port fills the array before or during execution.

## Interface

- ADDR_WIDTH, 32, byte address width of the fetch port
- DATA_WIDTH, 32, instruction word width
- DEPTH_WORDS, 1024, array depth in words; power of two, ≥2
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- instr_req  input  1  fetch request from core
- instr_addr  input  ADDR_WIDTH  fetch byte address
- instr_gnt  output  1  request accepted this cycle
- instr_rvalid  output  1  instr_rdata valid this cycle
- instr_rdata  output  DATA_WIDTH  fetched word
- gnt_wait  input  4  extra cycles before grant (0 = same-cycle grant)
- rvalid_wait  input  4  extra cycles between grant and rvalid (0 = rvalid the cycle after grant)
- load_we  input  1  array write enable
- load_idx  input  $clog2(DEPTH_WORDS)  word index to write
- load_data  input  DATA_WIDTH  word to write
- fetch_count  output  32  completed responses since reset

## Operation

- Index = instr_addr[$clog2(DEPTH_WORDS)+1:2]. Bits [1:0] are ignored. Higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- The array is not cleared by rst. Contents persist across reset.
- At most one outstanding transaction.
- States:
  - IDLE: no request pending.
  - GNT_WAIT: request seen, grant counter running.
  - RESP_WAIT: granted, response counter running.
- IDLE, instr_req=1:
  - gnt_wait is latched into a grant counter.
  - If gnt_wait=0, instr_gnt is asserted combinationally in the same cycle and the responder goes to RESP_WAIT.
  - Otherwise it goes to GNT_WAIT.
- GNT_WAIT:
  - The counter decrements each cycle.
  - instr_gnt is asserted in the cycle the counter reads 1, provided instr_req is still high. The responder then goes to RESP_WAIT.
  - If instr_req drops before grant (protocol violation), it returns to IDLE. No grant, no response, no count.
- Grant cycle actions:
  - The indexed word is read into a data register (read-before-write against a same-cycle load to the same index).
  - rvalid_wait is latched into a response counter.
- RESP_WAIT:
  - The counter decrements each cycle.
  - instr_rvalid=1 for exactly one cycle when it expires. instr_rdata = data register, and fetch_count increments.
- Back-to-back: in the rvalid cycle, a new instr_req is evaluated exactly as in IDLE. With gnt_wait=0, instr_gnt and instr_rvalid may both be high in that cycle.
- instr_rdata is 0 whenever instr_rvalid=0.
- Load port: when load_we=1, load_data is written at load_idx on the clock edge. A load may occur in any state.
- fetch_count wraps from 2^32-1 to 0.

## Timing

- Reset values: instr_gnt=0, instr_rvalid=0, instr_rdata=0, fetch_count=0, state IDLE, both counters 0.
- Latency:
  - Grant occurs gnt_wait cycles after instr_req first rises.
  - rvalid occurs rvalid_wait+1 cycles after the grant cycle.
  - Minimum request-to-rvalid is therefore 1 cycle.
- Maximum throughput with both waits 0 is one word per cycle (grant in cycle t, rvalid in t+1, next grant also in t+1).
- instr_addr is sampled only in the grant cycle.
- gnt_wait and rvalid_wait are sampled only at the latch points. Changes mid-transaction do not affect that transaction.
- rst high on any edge aborts everything in flight. No rvalid is ever issued for an aborted grant. Outputs return to reset values in the following cycle. A load_we in the same cycle as rst is still performed.
- A load to an index whose fetch was already granted does not alter the returned word.

## Test plan

- Load idx 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193. Set gnt_wait=0, rvalid_wait=0, and hold req with addr 0,4,8,12 advanced on each gnt. -> gnt in 4 consecutive cycles, rvalid in the next 4 cycles with those words in order, fetch_count=4.
- gnt_wait=3, rvalid_wait=2, single req at addr 0x8 raised at cycle 10. -> gnt at cycle 13 only, rvalid at cycle 16 with 0x00200113, gnt/rvalid low elsewhere.
- Addr 0x1006 with DEPTH_WORDS=1024. -> returns the word at idx 1 (wrap plus low bits ignored).
- Grant at idx 5 (old 0xAAAAAAAA) with load_we to idx 5 = 0x55555555 in the same cycle, rvalid_wait=1. -> rvalid returns 0xAAAAAAAA. A following fetch of idx 5 returns 0x55555555.
- rst for one cycle between grant and rvalid with rvalid_wait=3. -> no rvalid ever for that fetch, fetch_count=0, array contents unchanged.
- gnt_wait=2, req dropped after 1 cycle. -> no gnt, no rvalid, state IDLE, fetch_count unchanged.
